// File: rtl/uart_pkg.sv
// Shared UART constants and the FIFO status bundle consumed by the CSR block.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH          = 8;
  localparam int unsigned UART_FIFO_ADDR_WIDTH     = 9;
  localparam int unsigned UART_FIFO_DEPTH          = 2 ** UART_FIFO_ADDR_WIDTH;
  localparam int unsigned UART_FIFO_AFULL_THRESH   = UART_FIFO_DEPTH - 4;
  localparam int unsigned UART_FIFO_AEMPTY_THRESH  = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/uart_sync_fifo_if.sv
// Handshake/status bundle between the bus-side user (master) and the FIFO (slave).
interface uart_sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  flush;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, flush,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/uart_fifo_ram.sv
// Simple dual-port RAM with a registered, resettable read port.
module uart_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART FIFO: pointers, occupancy, threshold flags, sticky errors, flush.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = UART_FIFO_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH  = (2 ** ADDR_WIDTH) - 4,
  parameter int unsigned AEMPTY_THRESH = UART_FIFO_AEMPTY_THRESH
) (
  input logic             clk,
  input logic             rst_n,
  uart_sync_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AFULL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 12) begin : g_bad_addr_width
    $error("uart_sync_fifo: ADDR_WIDTH must be in 1..12");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("uart_sync_fifo: AFULL_THRESH must be in 1..depth");
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("uart_sync_fifo: AEMPTY_THRESH must be in 0..depth-1");
  end

  logic [ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr_d;
  logic [ADDR_WIDTH-1:0] r_rd_ptr, w_rd_ptr_d;
  logic [ADDR_WIDTH:0]   r_count,  w_count_d;
  logic                  r_overflow, w_overflow_d;
  logic                  r_underflow, w_underflow_d;
  logic                  r_rd_valid;
  logic                  w_full, w_empty, w_wr_acc, w_rd_acc;
  fifo_status_t          w_status;

  assign w_full  = (r_count == CNT_DEPTH);
  assign w_empty = (r_count == '0);

  // Flush swallows same-cycle requests; full/empty block without pass/fall-through.
  assign w_wr_acc = !bus.flush && bus.wr_en && !w_full;
  assign w_rd_acc = !bus.flush && bus.rd_en && !w_empty;

  always_comb begin
    w_wr_ptr_d    = r_wr_ptr;
    w_rd_ptr_d    = r_rd_ptr;
    w_count_d     = r_count;
    w_overflow_d  = r_overflow;
    w_underflow_d = r_underflow;
    if (bus.flush) begin
      w_wr_ptr_d    = '0;
      w_rd_ptr_d    = '0;
      w_count_d     = '0;
      w_overflow_d  = 1'b0;
      w_underflow_d = 1'b0;
    end else begin
      if (w_wr_acc) w_wr_ptr_d = r_wr_ptr + PTR_ONE;
      if (w_rd_acc) w_rd_ptr_d = r_rd_ptr + PTR_ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_d = r_count + CNT_ONE;
        2'b01:   w_count_d = r_count - CNT_ONE;
        default: w_count_d = r_count;
      endcase
      if (bus.wr_en && w_full)  w_overflow_d  = 1'b1;
      if (bus.rd_en && w_empty) w_underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_count     <= w_count_d;
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
      r_rd_valid  <= w_rd_acc;
    end
  end

  uart_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wr_data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (bus.rd_data)
  );

  always_comb begin
    w_status              = '0;
    w_status.full         = w_full;
    w_status.empty        = w_empty;
    w_status.almost_full  = (r_count >= CNT_AFULL);
    w_status.almost_empty = (r_count <= CNT_AEMPTY);
    w_status.overflow     = r_overflow;
    w_status.underflow    = r_underflow;
  end

  assign bus.rd_valid     = r_rd_valid;
  assign bus.count        = r_count;
  assign bus.full         = w_status.full;
  assign bus.empty        = w_status.empty;
  assign bus.almost_full  = w_status.almost_full;
  assign bus.almost_empty = w_status.almost_empty;
  assign bus.overflow     = w_status.overflow;
  assign bus.underflow    = w_status.underflow;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Scoreboard bench for uart_sync_fifo at depth 4, directed cases then random traffic.
module tb_uart_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) vif ();

  uart_sync_fifo #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents as a plain queue, plus expected popped words.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_last = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit exp_valid);
    int sz;
    sz = model_q.size();
    chk("count", int'(vif.count), sz);
    chk("full", int'(vif.full), int'(sz == DEPTH));
    chk("empty", int'(vif.empty), int'(sz == 0));
    chk("almost_full", int'(vif.almost_full), int'(sz >= AF));
    chk("almost_empty", int'(vif.almost_empty), int'(sz <= AE));
    chk("overflow", int'(vif.overflow), int'(m_ovf));
    chk("underflow", int'(vif.underflow), int'(m_unf));
    chk("rd_valid", int'(vif.rd_valid), int'(exp_valid));
    chk("rd_data_hold", int'(vif.rd_data), int'(m_last));
  endtask

  // One clock of stimulus; the model advances by the spec's acceptance rules.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    int sz;
    bit wacc, racc;
    logic [DW-1:0] v;
    vif.wr_en   = w;
    vif.wr_data = d;
    vif.rd_en   = r;
    vif.flush   = f;
    @(posedge clk);
    #1;
    sz   = model_q.size();
    wacc = w && !f && (sz < DEPTH);
    racc = r && !f && (sz > 0);
    if (f) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_unf = 1'b1;
    end
    if (racc) begin
      v = model_q.pop_front();
      exp_q.push_back(v);
      m_last = v;
    end
    if (wacc) model_q.push_back(d);
    check_outputs(racc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    if (rst_n && vif.rd_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL monitor_unexpected: rd_data %0h with nothing expected", vif.rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (vif.rd_data !== e) begin
          n_errors++;
          $display("FAIL monitor_data: got %0h expected %0h at %0t", vif.rd_data, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.wr_en = 1'b0;
    vif.wr_data = '0;
    vif.rd_en = 1'b0;
    vif.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0);
    rst_n = 1'b1;

    // Fill, then overflow attempt
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
    // Drain, then underflow attempt
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap-around: write 3, read 2, write 3, read 4
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous ops at count 2, then at full
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'hF0 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);

    // Flush with a write pending at count 3 and overflow set
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 3));
    end
    while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-burst with a read pending
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    vif.wr_en = 1'b0;
    vif.rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    exp_q.delete();
    m_last = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_outputs(1'b0);
    vif.rd_en = 1'b0;
    @(posedge clk);
    #1;
    check_outputs(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_sync_fifo.md
Name: uart_sync_fifo

Overview:
- Single-clock synchronous FIFO for UART TX/RX buffering, placed between the bus-side register interface and the UART shifter.
- Generalises the plain sync-read byte RAM into a true FIFO:
  - read/write pointers, occupancy count
  - full/empty and programmable almost-full/almost-empty flags
  - sticky overflow/underflow error flags
  - synchronous flush
- Read data is registered, one cycle of latency, qualified by rd_valid.

Parameters:
- DATA_WIDTH, 8, width of each entry in bits.
- ADDR_WIDTH, 9, log2 of depth; depth = 2**ADDR_WIDTH (512). Legal range 1..12.
- AFULL_THRESH, 2**ADDR_WIDTH-4, almost_full asserted when count >= AFULL_THRESH.
- AEMPTY_THRESH, 4, almost_empty asserted when count <= AEMPTY_THRESH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset. Asserts asynchronously; release is synchronous to clk.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  rd_data holds a newly popped entry this cycle.
- flush  input  1  synchronous clear of pointers, count and error flags.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..depth.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset values (rst_n low):
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - rd_valid = 0, rd_data = 0, overflow = 0, underflow = 0
  - Storage array is not reset.
- Write acceptance:
  - Write accepted iff wr_en && !full (full as registered at the start of the cycle).
  - Accepted write stores wr_data at wr_ptr; wr_ptr increments modulo depth.
- Read acceptance and latency:
  - Read accepted iff rd_en && !empty.
  - Accepted read fetches mem[rd_ptr]; rd_ptr increments modulo depth.
  - rd_data and rd_valid are updated on the following edge: 1-cycle latency.
  - rd_valid is high for exactly one cycle per accepted read.
  - rd_data holds its last value when no read is accepted.
- Simultaneous write and read:
  - Both accepted when neither is blocked; count unchanged.
  - When full, the write is rejected even if a read is accepted that same cycle (no pass-through).
  - When empty, the read is rejected even if a write is accepted that same cycle (no fall-through). The written word appears no earlier than the next cycle's read.
- Count update:
  - count += 1 on write only; count -= 1 on read only; unchanged on both or neither.
  - Flags derive combinationally from registered count; no extra delay.
- Wrap-around: pointers are ADDR_WIDTH bits and wrap naturally. Ordering is preserved across wrap for any interleaving.
- Error flags:
  - overflow sets on wr_en && full.
  - underflow sets on rd_en && empty.
  - Both stay set until flush or reset. Rejected operations change no other state.
- Flush:
  - Pointers and count go to 0; overflow, underflow and rd_valid go to 0 on the next edge.
  - Flush has priority over same-cycle wr_en/rd_en; those requests are ignored and set no error flags.
  - rd_data is unchanged by flush.
- Reset mid-operation: any in-flight read is discarded; rd_valid does not assert after reset release.
- Parameter checks at elaboration:
  - AFULL_THRESH must be in 1..depth.
  - AEMPTY_THRESH must be in 0..depth-1.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_WIDTH = 8 and the default FIFO depth constants
  - the fifo status struct {full, empty, almost_full, almost_empty, overflow, underflow} used by the UART CSR block.
- One sub-module: uart_fifo_ram.
  - Simple dual-port RAM: write port (we, waddr, wdata) and registered read port (re, raddr, rdata).
  - Its rdata register is reset to 0 by rst_n.
- Pointer/count/flag logic stays in uart_sync_fifo.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, depth 4, AFULL_THRESH=3, AEMPTY_THRESH=1):
- Reset, then write 0xA1,0xA2,0xA3,0xA4 on consecutive cycles:
  - count 1,2,3,4
  - almost_full at count 3; full at 4; empty clears after the first write
  - a 5th write of 0xA5 is dropped and overflow = 1.
- Read 4 times back-to-back:
  - rd_valid pulses with rd_data 0xA1..0xA4, each one cycle after its rd_en
  - empty = 1 after the 4th read
  - a 5th rd_en sets underflow = 1 and gives no rd_valid.
- Wrap-around:
  - Write 3, read 2, then write 3 more: count = 4.
  - Reading 4 returns the 4 remaining words in write order across the pointer wrap.
- Simultaneous ops:
  - At count 2, assert wr_en+rd_en for 5 cycles: count stays 2; data order is preserved.
  - At full, wr_en+rd_en: read succeeds, write rejected, count = 3, overflow set.
- Flush with wr_en=1 at count 3 and overflow=1:
  - Next cycle count = 0, empty = 1, overflow = 0.
  - No write occurs; rd_data retains its prior value.
- Assert rst_n low asynchronously mid-burst (count 2, read pending):
  - All outputs take reset values immediately.
  - After release, no rd_valid pulse; count = 0.
